// File: rtl/ex_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_result_stage
// Description : Registered execute-result stage for the RV64 core. Captures
//               each ALU result with its rd tag and PC, sign-extends *W op
//               results, and hands entries to the memory stage over a
//               valid/ready handshake through a 2-entry skid buffer. The head
//               entry doubles as a forwarding source.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_result_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    // Upstream (ALU) side
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_we_i,
    input  logic              word_op_i,
    input  logic [XLEN-1:0]   pc_i,
    // Downstream (memory stage) side
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_result_o,
    output logic [REG_AW-1:0] out_rd_addr_o,
    output logic              out_rd_we_o,
    output logic [XLEN-1:0]   out_pc_o,
    // Forwarding tap on the head entry
    output logic              fwd_valid_o,
    output logic [REG_AW-1:0] fwd_rd_addr_o,
    output logic [XLEN-1:0]   fwd_result_o
);

    // Occupancy of the two storage slots. Head is always the older entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;

    // Head slot: drives the outputs directly
    logic [XLEN-1:0]   head_result_q;
    logic [REG_AW-1:0] head_rd_q;
    logic              head_we_q;
    logic [XLEN-1:0]   head_pc_q;

    // Skid slot: absorbs the one extra entry accepted while the head stalls
    logic [XLEN-1:0]   skid_result_q;
    logic [REG_AW-1:0] skid_rd_q;
    logic              skid_we_q;
    logic [XLEN-1:0]   skid_pc_q;

    logic              w_accept;
    logic              w_pop;
    logic              w_head_load_in;
    logic              w_head_load_skid;
    logic              w_skid_load;
    logic [XLEN-1:0]   w_in_result;
    logic              w_in_we;

    // Readiness comes from state alone so the input handshake never sees
    // a combinational path from out_ready_i.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);

    assign w_accept = in_valid_i & in_ready_o;
    assign w_pop    = out_valid_o & out_ready_i;

    // *W ops produce a 32-bit result that must be sign-extended to XLEN;
    // writes to x0 are squashed at capture so they never forward.
    assign w_in_result = word_op_i ? {{(XLEN-32){alu_result_i[31]}}, alu_result_i[31:0]}
                                   : alu_result_i;
    assign w_in_we     = rd_we_i & (rd_addr_i != '0);

    // Next-state and slot-load decode; flush overrides any accept or pop.
    always_comb begin
        state_d          = state_q;
        w_head_load_in   = 1'b0;
        w_head_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d        = ST_ONE;
                        w_head_load_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_head_load_in = 1'b1;
                    end else if (w_accept) begin
                        state_d     = ST_FULL;
                        w_skid_load = 1'b1;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        state_d          = ST_ONE;
                        w_head_load_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head slot: loads a fresh input or promotes the skid entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_result_q <= '0;
            head_rd_q     <= '0;
            head_we_q     <= 1'b0;
            head_pc_q     <= '0;
        end else if (w_head_load_in) begin
            head_result_q <= w_in_result;
            head_rd_q     <= rd_addr_i;
            head_we_q     <= w_in_we;
            head_pc_q     <= pc_i;
        end else if (w_head_load_skid) begin
            head_result_q <= skid_result_q;
            head_rd_q     <= skid_rd_q;
            head_we_q     <= skid_we_q;
            head_pc_q     <= skid_pc_q;
        end
    end

    // Skid slot: captures an input arriving while the head is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_we_q     <= 1'b0;
            skid_pc_q     <= '0;
        end else if (w_skid_load) begin
            skid_result_q <= w_in_result;
            skid_rd_q     <= rd_addr_i;
            skid_we_q     <= w_in_we;
            skid_pc_q     <= pc_i;
        end
    end

    assign out_result_o  = head_result_q;
    assign out_rd_addr_o = head_rd_q;
    assign out_rd_we_o   = head_we_q;
    assign out_pc_o      = head_pc_q;

    // Forwarding is a zero-latency tap on the head slot.
    assign fwd_valid_o   = out_valid_o & head_we_q;
    assign fwd_rd_addr_o = head_rd_q;
    assign fwd_result_o  = head_result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_result_stage
// Description : Scoreboard bench for ex_result_stage. The driver predicts
//               each accepted entry and queues it; a negedge monitor compares
//               the head against the queue and retires entries on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_result_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] alu_result_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_we_i = 1'b0;
    logic        word_op_i = 1'b0;
    logic [63:0] pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] out_result_o;
    logic [4:0]  out_rd_addr_o;
    logic        out_rd_we_o;
    logic [63:0] out_pc_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_addr_o;
    logic [63:0] fwd_result_o;

    ex_result_stage #(.XLEN(64), .REG_AW(5)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .alu_result_i  (alu_result_i),
        .rd_addr_i     (rd_addr_i),
        .rd_we_i       (rd_we_i),
        .word_op_i     (word_op_i),
        .pc_i          (pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_result_o  (out_result_o),
        .out_rd_addr_o (out_rd_addr_o),
        .out_rd_we_o   (out_rd_we_o),
        .out_pc_o      (out_pc_o),
        .fwd_valid_o   (fwd_valid_o),
        .fwd_rd_addr_o (fwd_rd_addr_o),
        .fwd_result_o  (fwd_result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] pc;
    } ent_t;

    ent_t        exp_q[$];     // entries the stage should currently hold, oldest first
    logic [63:0] popped[$];    // results retired by the monitor, in order
    int          checks = 0;
    int          failures = 0;
    logic        pend_acc = 1'b0;
    logic        pend_flush = 1'b0;
    ent_t        pend_ent;
    logic [63:0] pc_ctr = 64'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference behaviour of one captured instruction.
    function automatic ent_t predict(input logic [63:0] res, input logic [4:0] rd,
                                     input logic we, input logic wo, input logic [63:0] pc);
        ent_t e;
        int   low;
        low   = int'(res[31:0]);
        e.res = wo ? 64'(longint'(low)) : res;
        e.rd  = rd;
        e.we  = we && (rd != 5'd0);
        e.pc  = pc;
        return e;
    endfunction

    // One cycle of stimulus: commit the previous edge's effect on the
    // expected contents, then present new inputs for the next edge.
    task automatic drive(input logic v, input logic [63:0] res, input logic [4:0] rd,
                         input logic we, input logic wo, input logic ordy, input logic fl);
        @(posedge clk_i);
        #1;
        if (pend_flush) exp_q.delete();
        else if (pend_acc) exp_q.push_back(pend_ent);
        in_valid_i   = v;
        alu_result_i = res;
        rd_addr_i    = rd;
        rd_we_i      = we;
        word_op_i    = wo;
        pc_i         = pc_ctr;
        out_ready_i  = ordy;
        flush_i      = fl;
        pend_flush   = fl;
        pend_acc     = v && (exp_q.size() < 2);
        pend_ent     = predict(res, rd, we, wo, pc_ctr);
        pc_ctr       = pc_ctr + 64'd4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compare the presented head with the oldest expected entry and
    // retire it when the memory stage takes it.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("in_ready", {63'd0, in_ready_o}, {63'd0, exp_q.size() < 2});
            chk("out_valid", {63'd0, out_valid_o}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("out_result", out_result_o, exp_q[0].res);
                chk("out_rd", {59'd0, out_rd_addr_o}, {59'd0, exp_q[0].rd});
                chk("out_we", {63'd0, out_rd_we_o}, {63'd0, exp_q[0].we});
                chk("out_pc", out_pc_o, exp_q[0].pc);
                chk("fwd_valid", {63'd0, fwd_valid_o}, {63'd0, exp_q[0].we});
                chk("fwd_rd", {59'd0, fwd_rd_addr_o}, {59'd0, exp_q[0].rd});
                chk("fwd_result", fwd_result_o, exp_q[0].res);
                if (out_ready_i) begin
                    popped.push_back(exp_q[0].res);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("fwd_valid_empty", {63'd0, fwd_valid_o}, 64'd0);
            end
        end
    end

    int k;

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_fwd_valid", {63'd0, fwd_valid_o}, 64'd0);
        chk("rst_out_we", {63'd0, out_rd_we_o}, 64'd0);
        chk("rst_out_result", out_result_o, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd_addr_o}, 64'd0);
        chk("rst_out_pc", out_pc_o, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        #20;
        rst_ni = 1'b1;
        idle(2);

        // Single op
        drive(1'b1, 64'h0000_0000_8000_0001, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("single_result", out_result_o, 64'h0000_0000_8000_0001);
        chk("single_fwd_valid", {63'd0, fwd_valid_o}, 64'd1);
        chk("single_fwd_rd", {59'd0, fwd_rd_addr_o}, 64'd5);

        // Word ops: negative and positive 32-bit results
        drive(1'b1, 64'h0000_0000_8000_0001, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("word_neg", out_result_o, 64'hFFFF_FFFF_8000_0001);
        drive(1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("word_pos", out_result_o, 64'h0000_0000_7FFF_FFFF);

        // x0 destination
        drive(1'b1, 64'h1234, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("x0_we", {63'd0, out_rd_we_o}, 64'd0);
        chk("x0_fwd_valid", {63'd0, fwd_valid_o}, 64'd0);
        chk("x0_out_valid", {63'd0, out_valid_o}, 64'd1);
        idle(2);

        // Backpressure: source holds each value until it is taken
        popped.delete();
        k = 1;
        for (int c = 0; c < 16; c++) begin
            drive(k <= 4, 64'(k), 5'(k + 1), 1'b1, 1'b0, c >= 5, 1'b0);
            if (pend_acc) k++;
            if (c == 3) begin
                chk("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
                chk("bp_hold", out_result_o, 64'd1);
            end
        end
        chk("bp_count", 64'(popped.size()), 64'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("bp_order", popped[i], 64'(i + 1));

        // Flush while FULL with the output ready
        drive(1'b1, 64'hA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hC, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("flush_full_valid", {63'd0, out_valid_o}, 64'd0);
        chk("flush_full_ready", {63'd0, in_ready_o}, 64'd1);

        // Flush in ONE with a simultaneous input
        drive(1'b1, 64'hD, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hE, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("flush_one_valid", {63'd0, out_valid_o}, 64'd0);
        idle(1);
        chk("flush_no_capture", {63'd0, out_valid_o}, 64'd0);

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 9) < 7,
                  {$urandom, $urandom},
                  5'($urandom_range(0, 31)),
                  1'($urandom),
                  1'($urandom),
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 4);
        end

        // Asynchronous reset mid-stream, between edges
        drive(1'b1, 64'h55, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h66, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h77, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        exp_q.delete();
        pend_acc   = 1'b0;
        pend_flush = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("arst_fwd_valid", {63'd0, fwd_valid_o}, 64'd0);
        chk("arst_out_result", out_result_o, 64'd0);
        chk("arst_out_pc", out_pc_o, 64'd0);
        chk("arst_out_rd", {59'd0, out_rd_addr_o}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready_o}, 64'd1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        drive(1'b1, 64'h99, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("post_rst_result", out_result_o, 64'h99);
        chk("post_rst_valid", {63'd0, out_valid_o}, 64'd1);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
